// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, frame type and helpers for the digit scanner
package display_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam int         DEF_DIGITS = 4;

    // Active-low gfedcba patterns for hex digits 0..F
    localparam logic [6:0] SEG_DIGIT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [4*DEF_DIGITS-1:0] digits;
        logic [DEF_DIGITS-1:0]   dp;
        logic [DEF_DIGITS-1:0]   blank;
    } frame_t;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// rtl/seven_segment_scanner_if.sv - frame update handshake between producer and scanner
interface seven_segment_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    upd_valid;
    logic                    upd_ready;
    logic [4*NUM_DIGITS-1:0] upd_digits;
    logic [NUM_DIGITS-1:0]   upd_dp;
    logic [NUM_DIGITS-1:0]   upd_blank;

    modport master (
        output upd_valid, upd_digits, upd_dp, upd_blank,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_digits, upd_dp, upd_blank,
        output upd_ready
    );
endinterface

// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - hex nibble to active-low gfedcba segment pattern
module seven_segment_decoder (
    input  logic [3:0] bin_in,
    output logic [6:0] hex_out
);
    always_comb begin
        hex_out = 7'h7F;
        case (bin_in)
            4'h0: hex_out = 7'b1000000;
            4'h1: hex_out = 7'b1111001;
            4'h2: hex_out = 7'b0100100;
            4'h3: hex_out = 7'b0110000;
            4'h4: hex_out = 7'b0011001;
            4'h5: hex_out = 7'b0010010;
            4'h6: hex_out = 7'b0000010;
            4'h7: hex_out = 7'b1111000;
            4'h8: hex_out = 7'b0000000;
            4'h9: hex_out = 7'b0010000;
            4'hA: hex_out = 7'b0001000;
            4'hB: hex_out = 7'b0000011;
            4'hC: hex_out = 7'b1000110;
            4'hD: hex_out = 7'b0100001;
            4'hE: hex_out = 7'b0000110;
            4'hF: hex_out = 7'b0001110;
            default: hex_out = 7'h7F;
        endcase
    end
endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - time-multiplexed display driver with tear-free frame commit
module seven_segment_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seven_segment_scanner_if.slave  upd,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);
    localparam int CNT_W = cnt_width(REFRESH_DIV);
    localparam int IDX_W = cnt_width(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    phase_e           phase_q, phase_d;
    logic             slot_end, frame_end;

    logic [4*NUM_DIGITS-1:0] act_digits_q, pend_digits_q;
    logic [NUM_DIGITS-1:0]   act_dp_q, pend_dp_q;
    logic [NUM_DIGITS-1:0]   act_blank_q, pend_blank_q;
    logic                    pend_full_q;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d, dec_seg;
    logic                  dp_q, dp_d, tick_q;
    logic                  drive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            phase_q <= PH_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    // Phase is registered alongside cnt so it always describes the current cnt_q
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        phase_d = (cnt_d < BLANK_LIM) ? PH_BLANK : PH_DRIVE;
    end

    assign upd.upd_ready = ~pend_full_q;

    // Ready is low while pending is full, so a transfer and a commit are exclusive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '1;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '0;
            pend_full_q   <= 1'b0;
        end else if (upd.upd_valid && !pend_full_q) begin
            pend_digits_q <= upd.upd_digits;
            pend_dp_q     <= upd.upd_dp;
            pend_blank_q  <= upd.upd_blank;
            pend_full_q   <= 1'b1;
        end else if (frame_end && pend_full_q) begin
            act_digits_q <= pend_digits_q;
            act_dp_q     <= pend_dp_q;
            act_blank_q  <= pend_blank_q;
            pend_full_q  <= 1'b0;
        end
    end

    seven_segment_decoder u_dec (
        .bin_in  (act_digits_q[{idx_q, 2'b00} +: 4]),
        .hex_out (dec_seg)
    );

    always_comb begin
        drive = (phase_q == PH_DRIVE) && !act_blank_q[idx_q];
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (drive) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = dec_seg;
            dp_d  = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q   <= '1;
            seg_q  <= SEG_OFF;
            dp_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            tick_q <= frame_end;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - scoreboard bench for the multiplexed display scanner
module tb_seven_segment_scanner;
    import display_pkg::*;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;
    localparam int FR = N * R;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_segment_scanner_if #(.NUM_DIGITS(N)) upd_if ();
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         frame_tick;

    seven_segment_scanner #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd        (upd_if.slave),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    int checks = 0;
    int failures = 0;
    int t = 0;
    int last_xfer_t = -1;
    int tick_seen = 0;
    frame_t active_m;
    frame_t pend_q[$];
    frame_t offer_q[$];

    function automatic frame_t mk(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        frame_t f;
        f.digits = d;
        f.dp = p;
        f.blank = b;
        return f;
    endfunction

    task automatic model_reset();
        active_m = mk(16'h0000, 4'h0, 4'hF);
        pend_q.delete();
        offer_q.delete();
        t = 0;
    endtask

    // One clock: drive the head of offer_q, advance, compare outputs against the time-indexed model
    task automatic cycle();
        frame_t f;
        bit xfer;
        int cnt, idx;
        bit drv;
        logic [3:0] an_e, nib;
        logic [6:0] seg_e;
        logic dp_e, tick_e, rdy_e;
        if (offer_q.size() > 0) begin
            f = offer_q[0];
            upd_if.upd_valid  = 1'b1;
            upd_if.upd_digits = f.digits;
            upd_if.upd_dp     = f.dp;
            upd_if.upd_blank  = f.blank;
        end else begin
            upd_if.upd_valid = 1'b0;
        end
        #1;
        xfer = upd_if.upd_valid && upd_if.upd_ready;
        @(posedge clk);
        #1;
        cnt = t % R;
        idx = (t / R) % N;
        drv = (cnt >= B) && !active_m.blank[idx];
        nib = active_m.digits[idx*4 +: 4];
        an_e   = drv ? ~(4'b0001 << idx) : 4'hF;
        seg_e  = drv ? SEG_DIGIT[nib] : SEG_OFF;
        dp_e   = drv ? ~active_m.dp[idx] : 1'b1;
        tick_e = (t % FR) == FR - 1;
        checks += 4;
        if (an !== an_e) begin failures++; $display("FAIL an t=%0d got=%b exp=%b", t, an, an_e); end
        if (seg !== seg_e) begin failures++; $display("FAIL seg t=%0d got=%b exp=%b", t, seg, seg_e); end
        if (dp !== dp_e) begin failures++; $display("FAIL dp t=%0d got=%b exp=%b", t, dp, dp_e); end
        if (frame_tick !== tick_e) begin failures++; $display("FAIL frame_tick t=%0d got=%b exp=%b", t, frame_tick, tick_e); end
        if (tick_e && pend_q.size() > 0) active_m = pend_q.pop_front();
        if (xfer) begin
            pend_q.push_back(offer_q.pop_front());
            last_xfer_t = t;
        end
        rdy_e = (pend_q.size() == 0);
        checks++;
        if (upd_if.upd_ready !== rdy_e) begin failures++; $display("FAIL upd_ready t=%0d got=%b exp=%b", t, upd_if.upd_ready, rdy_e); end
        if (frame_tick === 1'b1) tick_seen++;
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_idle(input string name);
        int guard = 0;
        while ((offer_q.size() > 0 || pend_q.size() > 0) && guard < 300) begin
            cycle();
            guard++;
        end
        checks++;
        if (guard >= 300) begin failures++; $display("FAIL %s timeout got=%0d exp=<300", name, guard); end
    endtask

    task automatic test_reset();
        upd_if.upd_valid = 1'b0;
        upd_if.upd_digits = '0;
        upd_if.upd_dp = '0;
        upd_if.upd_blank = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%h exp=f", an); end
        if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp); end
        if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
        if (upd_if.upd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", upd_if.upd_ready); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_idle();
        int lit = 0;
        tick_seen = 0;
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (an !== 4'hF || seg !== 7'h7F) lit++;
        end
        checks += 2;
        if (lit != 0) begin failures++; $display("FAIL idle_dark got=%0d exp=0", lit); end
        if (tick_seen != 2) begin failures++; $display("FAIL idle_ticks got=%0d exp=2", tick_seen); end
    endtask

    task automatic test_frame();
        int d0 = 0;
        offer_q.push_back(mk(16'h3210, 4'h0, 4'h0));
        run_until_idle("frame_commit");
        for (int i = 0; i < FR; i++) begin
            cycle();
            if (an === 4'b1110 && seg === 7'b1000000) d0++;
        end
        checks++;
        if (d0 != R - B) begin failures++; $display("FAIL frame_digit0_cycles got=%0d exp=%0d", d0, R - B); end
        run(FR);
    endtask

    task automatic test_back_to_back();
        offer_q.push_back(mk(16'h4567, 4'h0, 4'h0));
        offer_q.push_back(mk(16'h89AB, 4'hF, 4'h0));
        run_until_idle("b2b");
        checks++;
        if (last_xfer_t % FR != 0) begin failures++; $display("FAIL b2b_accept_phase got=%0d exp=0", last_xfer_t % FR); end
        run(FR);
    endtask

    task automatic test_blank_dp();
        int d2_lit = 0, dp_lit = 0, d0_c = 0;
        offer_q.push_back(mk(16'hFEDC, 4'b0001, 4'b0100));
        run_until_idle("blank_dp");
        for (int i = 0; i < FR; i++) begin
            cycle();
            if (an[2] === 1'b0) d2_lit++;
            if (dp === 1'b0) begin
                dp_lit++;
                if (an === 4'b1110 && seg === 7'b1000110) d0_c++;
            end
        end
        checks += 3;
        if (d2_lit != 0) begin failures++; $display("FAIL blank_digit2 got=%0d exp=0", d2_lit); end
        if (dp_lit != R - B) begin failures++; $display("FAIL dp_cycles got=%0d exp=%0d", dp_lit, R - B); end
        if (d0_c != R - B) begin failures++; $display("FAIL dp_on_digit0_C got=%0d exp=%0d", d0_c, R - B); end
    endtask

    task automatic test_tick_offer();
        int guard = 0, low = 0, acc;
        while (t % FR != FR - 1 && guard < 100) begin cycle(); guard++; end
        acc = t;
        offer_q.push_back(mk(16'h1357, 4'h0, 4'h0));
        cycle();
        checks++;
        if (last_xfer_t != acc) begin failures++; $display("FAIL tick_offer_accept got=%0d exp=%0d", last_xfer_t, acc); end
        while (upd_if.upd_ready === 1'b0 && low < 100) begin low++; cycle(); end
        checks++;
        if (low != FR) begin failures++; $display("FAIL tick_offer_deferral got=%0d exp=%0d", low, FR); end
        run(R);
    endtask

    task automatic test_reset_mid();
        int guard = 0, lit = 0;
        offer_q.push_back(mk(16'h2468, 4'h0, 4'h0));
        while ((offer_q.size() > 0 || t % FR != 20) && guard < 200) begin cycle(); guard++; end
        checks += 2;
        if (pend_q.size() != 1 || guard >= 200) begin failures++; $display("FAIL mid_setup got=%0d exp=1", pend_q.size()); end
        if (an !== 4'b1011) begin failures++; $display("FAIL mid_pre_lit got=%b exp=1011", an); end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (an !== 4'hF) begin failures++; $display("FAIL mid_async_an got=%h exp=f", an); end
        if (seg !== 7'h7F) begin failures++; $display("FAIL mid_async_seg got=%h exp=7f", seg); end
        if (dp !== 1'b1) begin failures++; $display("FAIL mid_async_dp got=%b exp=1", dp); end
        if (upd_if.upd_ready !== 1'b1) begin failures++; $display("FAIL mid_async_ready got=%b exp=1", upd_if.upd_ready); end
        upd_if.upd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FR; i++) begin
            cycle();
            if (an !== 4'hF) lit++;
        end
        checks++;
        if (lit != 0) begin failures++; $display("FAIL mid_post_dark got=%0d exp=0", lit); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame();
        test_back_to_back();
        test_blank_dp();
        test_tick_offer();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed display controller that shares a single `seven_segment_decoder` across `NUM_DIGITS` common-anode digits of the board display. It accepts a full digit frame through a valid/ready handshake and holds it in a pending buffer. At the next frame boundary it commits the buffer to the active frame, so the display never tears. It then scans the digits with a programmable refresh period and an anti-ghosting blank interval. It sits between the piano note/octave logic and the board's `an`/`seg`/`dp` pins.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits, ≥2.
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz), ≥2.
- `BLANK_CYCLES`, 1000: leading cycles of each slot with all anodes off, 0 ≤ BLANK_CYCLES < REFRESH_DIV.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `upd_valid`  in  1  new frame offered.
- `upd_ready`  out  1  pending buffer empty; transfer occurs on `upd_valid && upd_ready`.
- `upd_digits`  in  4*NUM_DIGITS  nibble per digit; digit i at bits [4i+3:4i], digit 0 rightmost.
- `upd_dp`  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- `upd_blank`  in  NUM_DIGITS  1 = digit dark for the whole slot.
- `an`  out  NUM_DIGITS  anodes, active-low.
- `seg`  out  7  segments gfedcba (bit 0 = a), active-low, taken from the decoder.
- `dp`  out  1  decimal point, active-low.
- `frame_tick`  out  1  one-cycle pulse at the end of each full scan.

## Operation
- State: slot counter `cnt` (0..REFRESH_DIV-1, width $clog2(REFRESH_DIV)), digit index `idx` (0..NUM_DIGITS-1), active frame registers, pending frame registers, `pend_full` flag.
- Slot FSM, two phases per slot:
  - BLANK while cnt < BLANK_CYCLES.
  - DRIVE otherwise.
  - `cnt` wraps at REFRESH_DIV-1. On wrap, `idx` increments mod NUM_DIGITS and the phase returns to BLANK.
- Decoder input = active nibble[idx]. Decoder output is registered into `seg`.
- DRIVE with active blank[idx]=0: an = ~(1<<idx), seg = decoded pattern, dp = ~active_dp[idx].
- BLANK, or blank[idx]=1: an = all 1, seg = 7'h7F, dp = 1.
- Handshake:
  - upd_ready = ~pend_full.
  - A transfer copies upd_* into the pending registers and sets pend_full.
  - upd_* is ignored while upd_ready=0. The producer holds valid and data until ready.
- Commit: on the cycle where idx=NUM_DIGITS-1 and cnt=REFRESH_DIV-1 (the frame_tick cycle), if pend_full then active ← pending and pend_full clears.
- A transfer and a commit never coincide, because ready=0 whenever pend_full=1.
- A frame accepted during the final cycle of a frame commits at the next frame_tick, not the current one.
- Reset:
  - an = all 1, seg = 7'h7F, dp = 1, frame_tick = 0, upd_ready = 1.
  - cnt = 0, idx = 0, phase BLANK.
  - Active digits = 0, active blank = all 1 (display dark until the first commit), pending cleared.
- Reset mid-frame discards both active and pending data immediately; no partial commit.

## Timing
- `an`, `seg`, `dp`, `frame_tick` are registered and reflect the (cnt, idx) state with 1 cycle latency.
- The decoder is combinational between the active registers and the output register, so no extra latency.
- Slot = REFRESH_DIV cycles, of which REFRESH_DIV-BLANK_CYCLES have the anode low.
- Frame = NUM_DIGITS·REFRESH_DIV cycles.
- Timing of a new frame relative to its transfer:
  - First visible on digit 0, at the first DRIVE cycle after the next frame_tick.
  - Worst-case latency from transfer ≈ NUM_DIGITS·REFRESH_DIV + BLANK_CYCLES + 1 cycles.
- `upd_ready` rises the cycle after the commit edge.
- BLANK_CYCLES=0: an changes directly from one digit to the next with no dark cycle. At most one anode is ever low.

## Structure
- Package `display_pkg`:
  - Segment constants: SEG_OFF = 7'h7F, digit pattern localparams for bench checks.
  - Width function for the counter.
  - Frame struct: digits/dp/blank.
- Natural sub-module: the existing `seven_segment_decoder` (`bin_in` 4 bits → `hex_out` 7 bits), instantiated once. No other sub-modules.
- Slot FSM, handshake buffer and output registers live in this module. Target 150–250 lines.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset, then no updates: an = 4'hF and seg = 7'h7F for 64 cycles. frame_tick pulses every 32 cycles.
- Transfer digits=16'h3210, dp=0, blank=0: after the next frame_tick, each slot shows 2 dark cycles, then 6 cycles of:
  - an=1110 with seg=7'b1000000,
  - an=1101 with 7'b1111001,
  - an=1011 with 7'b0100100,
  - an=0111 with 7'b0110000.
- Back-to-back offers:
  - Second upd_valid is held while upd_ready=0. It is accepted only the cycle after a commit.
  - The first frame displays for exactly one full frame before the second appears.
- Digits 16'hFEDC with blank=4'b0100 and dp=4'b0001:
  - Digit 2 stays dark for its whole slot.
  - dp=0 only during digit 0 DRIVE.
  - Digit 0 seg = decoder(4'hC).
- Assert rst_n=0 mid-DRIVE of digit 2 with a frame pending: outputs are dark immediately (asynchronous). After release, upd_ready=1 and the display stays dark.
- Offer a frame at the cycle of frame_tick: commit is deferred to the following frame_tick (32 cycles later).
